// File: rtl/fifo_mem_ctrl_pkg.sv
// fifo_mem_ctrl_pkg: shared FIFO status encodings and default sizes
package fifo_mem_ctrl_pkg;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_MAIN_SIZE = 2;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_MID = 2'd1, ST_FULL = 2'd2} state_t;
endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// fifo_mem_ctrl_if: push/pop requests, memory strobes/pointers and status flags
// slave = controller side (takes push/pop/push_data), master = requester side
interface fifo_mem_ctrl_if import fifo_mem_ctrl_pkg::*; #(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int MAIN_SIZE = DEF_MAIN_SIZE
) ();
  logic                 push, pop;
  logic [DATA_SIZE-1:0] push_data, mem_data_in;
  logic                 mem_write, mem_read, pop_valid;
  logic [MAIN_SIZE-1:0] mem_wr_ptr, mem_rd_ptr;
  logic [MAIN_SIZE:0]   count;
  logic                 full, empty, almost_full, almost_empty, overflow, underflow;
  modport slave (
    input  push, pop, push_data,
    output mem_write, mem_read, mem_wr_ptr, mem_rd_ptr, mem_data_in, pop_valid,
           count, full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport master (
    output push, pop, push_data,
    input  mem_write, mem_read, mem_wr_ptr, mem_rd_ptr, mem_data_in, pop_valid,
           count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_ctrl_ptr_counter.sv
// fifo_mem_ctrl_ptr_counter: wrapping pointer counter with enable
// ports: clk, reset (async high), en (advance), q (pointer value)
module fifo_mem_ctrl_ptr_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: pointer/flag controller for a 4x8 dual-pointer FIFO memory
// ports: clk, reset (async high), bus (fifo_mem_ctrl_if.slave: requests, strobes, flags)
module fifo_mem_ctrl import fifo_mem_ctrl_pkg::*; #(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int MAIN_SIZE = DEF_MAIN_SIZE,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input logic clk,
  input logic reset,
  fifo_mem_ctrl_if.slave bus
);
  localparam int CW = MAIN_SIZE + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** MAIN_SIZE);
  state_t state, state_nx;
  logic [CW-1:0] wr_ptr, rd_ptr, count, count_nx;
  logic push_acc, pop_acc;
  // gating with reset keeps strobes quiet while reset is held
  assign push_acc = bus.push & (state != ST_FULL) & ~reset;
  assign pop_acc  = bus.pop & (state != ST_EMPTY) & ~reset;
  fifo_mem_ctrl_ptr_counter #(.W(CW)) u_wr (.clk(clk), .reset(reset), .en(push_acc), .q(wr_ptr));
  fifo_mem_ctrl_ptr_counter #(.W(CW)) u_rd (.clk(clk), .reset(reset), .en(pop_acc), .q(rd_ptr));
  // the extra pointer bit disambiguates full from empty in the difference
  assign count    = wr_ptr - rd_ptr;
  assign count_nx = count + CW'(push_acc) - CW'(pop_acc);
  always_comb begin
    state_nx = state;
    state_nx = (state == ST_EMPTY) ? (push_acc ? ST_MID : ST_EMPTY)
             : (state == ST_FULL)  ? (pop_acc ? ST_MID : ST_FULL)
             : (count_nx == DEPTH) ? ST_FULL
             : (count_nx == '0)    ? ST_EMPTY : ST_MID;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state            <= ST_EMPTY;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
      bus.pop_valid    <= 1'b0;
    end else begin
      state            <= state_nx;
      bus.almost_full  <= count_nx >= CW'(AF_THRESH);
      bus.almost_empty <= count_nx <= CW'(AE_THRESH);
      bus.overflow     <= bus.overflow | (bus.push & ~push_acc);
      bus.underflow    <= bus.underflow | (bus.pop & ~pop_acc);
      bus.pop_valid    <= pop_acc;
    end
  assign bus.mem_write   = push_acc;
  assign bus.mem_read    = pop_acc;
  assign bus.mem_wr_ptr  = wr_ptr[MAIN_SIZE-1:0];
  assign bus.mem_rd_ptr  = rd_ptr[MAIN_SIZE-1:0];
  assign bus.mem_data_in = DATA_SIZE'(bus.push_data);
  assign bus.count       = count;
  assign bus.full        = state == ST_FULL;
  assign bus.empty       = state == ST_EMPTY;
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// tb_fifo_mem_ctrl: directed bench for fifo_mem_ctrl with a 4x8 memory model
module tb_fifo_mem_ctrl;
  logic clk, reset;
  int n_cmp = 0, n_err = 0;
  logic [7:0] mem [4];
  logic [7:0] mem_q;
  logic [7:0] vals [4] = '{8'hFF, 8'hDD, 8'hEE, 8'hCC};
  logic [7:0] q [$];
  logic [7:0] exp_d;
  fifo_mem_ctrl_if #(.DATA_SIZE(8), .MAIN_SIZE(2)) bus ();
  fifo_mem_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_wr_ptr] <= bus.mem_data_in;
    if (bus.mem_read) mem_q <= mem[bus.mem_rd_ptr];
  end
  task automatic test_reset;
    reset = 1; bus.push = 1; bus.pop = 1; bus.push_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rst_wr_strobe got %b exp 0", bus.mem_write); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_rd_strobe got %b exp 0", bus.mem_read); end
    @(negedge clk); reset = 0; bus.push = 0; bus.pop = 0;
    #1;
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_err++; $display("FAIL rst_ae got %b exp 1", bus.almost_empty); end
    n_cmp++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b/%b exp 0/0", bus.full, bus.almost_full); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.mem_wr_ptr !== 2'd0 || bus.mem_rd_ptr !== 2'd0) begin n_err++; $display("FAIL rst_ptrs got %0d/%0d exp 0/0", bus.mem_wr_ptr, bus.mem_rd_ptr); end
    n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL rst_err got ov%b uf%b pv%b exp 000", bus.overflow, bus.underflow, bus.pop_valid); end
  endtask
  task automatic test_push;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.push = 1; bus.push_data = vals[i];
      #1;
      n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_wr_ptr !== 2'(i)) begin n_err++; $display("FAIL push%0d_strobe got wr%b ptr%0d exp 1/%0d", i, bus.mem_write, bus.mem_wr_ptr, i); end
      n_cmp++; if (bus.mem_data_in !== vals[i]) begin n_err++; $display("FAIL push%0d_data got %h exp %h", i, bus.mem_data_in, vals[i]); end
      @(posedge clk); #1;
      n_cmp++; if (bus.count !== 3'(i + 1)) begin n_err++; $display("FAIL push%0d_count got %0d exp %0d", i, bus.count, i + 1); end
      n_cmp++; if (bus.almost_full !== (i >= 2)) begin n_err++; $display("FAIL push%0d_af got %b exp %b", i, bus.almost_full, i >= 2); end
      n_cmp++; if (bus.full !== (i == 3) || bus.empty !== 1'b0) begin n_err++; $display("FAIL push%0d_full_empty got %b/%b exp %b/0", i, bus.full, bus.empty, i == 3); end
    end
  endtask
  task automatic test_overflow;
    @(negedge clk); bus.push = 1; bus.push_data = 8'h99;
    #1;
    n_cmp++; if (bus.mem_write !== 1'b0 || bus.mem_wr_ptr !== 2'd0) begin n_err++; $display("FAIL ovf_strobe got wr%b ptr%0d exp 0/0", bus.mem_write, bus.mem_wr_ptr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_count got %0d full%b exp 4/1", bus.count, bus.full); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    @(negedge clk); bus.push = 0;
    @(posedge clk); #1;
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
  endtask
  task automatic test_pop;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.pop = 1;
      #1;
      n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_rd_ptr !== 2'(i)) begin n_err++; $display("FAIL pop%0d_strobe got rd%b ptr%0d exp 1/%0d", i, bus.mem_read, bus.mem_rd_ptr, i); end
      @(posedge clk); #1;
      n_cmp++; if (bus.pop_valid !== 1'b1 || mem_q !== vals[i]) begin n_err++; $display("FAIL pop%0d_data got pv%b %h exp 1 %h", i, bus.pop_valid, mem_q, vals[i]); end
      n_cmp++; if (bus.count !== 3'(3 - i) || bus.empty !== (i == 3)) begin n_err++; $display("FAIL pop%0d_count got %0d empty%b exp %0d/%b", i, bus.count, bus.empty, 3 - i, i == 3); end
    end
    @(negedge clk); bus.pop = 1;
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL udf_strobe got %b exp 0", bus.mem_read); end
    @(posedge clk); #1;
    n_cmp++; if (bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0 || bus.count !== 3'd0) begin n_err++; $display("FAIL udf_flag got uf%b pv%b cnt%0d exp 1/0/0", bus.underflow, bus.pop_valid, bus.count); end
    @(negedge clk); bus.pop = 0;
  endtask
  task automatic test_back_to_back;
    logic [1:0] ew, er;
    ew = 2'd0; er = 2'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.push = 1; bus.push_data = 8'h11 * 8'(i + 1); q.push_back(bus.push_data); ew++;
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL b2b_pre_count got %0d exp 2", bus.count); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus.push = 1; bus.pop = 1; bus.push_data = 8'h30 + 8'(i);
      q.push_back(bus.push_data); exp_d = q.pop_front();
      #1;
      n_cmp++; if (bus.mem_wr_ptr !== ew || bus.mem_rd_ptr !== er || !bus.mem_write || !bus.mem_read) begin n_err++; $display("FAIL b2b%0d_ptrs got %0d/%0d exp %0d/%0d", i, bus.mem_wr_ptr, bus.mem_rd_ptr, ew, er); end
      ew++; er++;
      @(posedge clk); #1;
      n_cmp++; if (bus.count !== 3'd2 || bus.full !== 1'b0 || bus.empty !== 1'b0) begin n_err++; $display("FAIL b2b%0d_state got cnt%0d f%b e%b exp 2/0/0", i, bus.count, bus.full, bus.empty); end
      n_cmp++; if (bus.pop_valid !== 1'b1 || mem_q !== exp_d) begin n_err++; $display("FAIL b2b%0d_data got pv%b %h exp 1 %h", i, bus.pop_valid, mem_q, exp_d); end
    end
  endtask
  task automatic test_async_reset;
    @(negedge clk); bus.pop = 0; bus.push = 1; bus.push_data = 8'h77;
    @(negedge clk); bus.pop = 1;
    @(posedge clk); #1;
    n_cmp++; if (bus.count !== 3'd3 || bus.pop_valid !== 1'b1 || bus.almost_full !== 1'b1) begin n_err++; $display("FAIL ar_pre got cnt%0d pv%b af%b exp 3/1/1", bus.count, bus.pop_valid, bus.almost_full); end
    #2 reset = 1;
    #1;
    n_cmp++; if (bus.count !== 3'd0 || bus.mem_wr_ptr !== 2'd0 || bus.mem_rd_ptr !== 2'd0) begin n_err++; $display("FAIL ar_count got cnt%0d wp%0d rp%0d exp 0/0/0", bus.count, bus.mem_wr_ptr, bus.mem_rd_ptr); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin n_err++; $display("FAIL ar_flags got e%b ae%b f%b af%b exp 1/1/0/0", bus.empty, bus.almost_empty, bus.full, bus.almost_full); end
    n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL ar_err got ov%b uf%b pv%b exp 000", bus.overflow, bus.underflow, bus.pop_valid); end
    n_cmp++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin n_err++; $display("FAIL ar_strobes got %b/%b exp 0/0", bus.mem_write, bus.mem_read); end
    @(negedge clk); reset = 0; bus.push = 0; bus.pop = 0;
  endtask
  initial begin
    test_reset();
    test_push();
    test_overflow();
    test_pop();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
